// File: rtl/mult_rr_scheduler.sv
// Round-robin front end that time-shares one 4x4 unsigned multiplier between NREQ
// requesters; operands and product are registered so the multiplier is one full stage.

module main (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] o
);
    assign o = {4'b0, x} * {4'b0, y};
endmodule

// state | meaning
// IDLE  | arbitrating, req_ready reflects round-robin pick
// CALC  | registered operands feeding the multiplier
// DONE  | product held on res_data until consumer takes it
module mult_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_x,
    input  logic [4*NREQ-1:0]   req_y,
    output logic [NREQ-1:0]     req_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [7:0]          res_data,
    output logic [ID_W-1:0]     res_id,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   gnt_id_q;
    logic [3:0]        op_x_q;
    logic [3:0]        op_y_q;
    logic [7:0]        res_data_q;
    logic [ID_W-1:0]   res_id_q;
    logic              res_valid_q;
    logic              busy_q;
    logic [CNT_W-1:0]  op_count_q;

    logic [NREQ-1:0]   gnt_d;
    logic [ID_W-1:0]   gnt_idx_d;
    logic              gnt_any_d;
    logic [3:0]        sel_x_d;
    logic [3:0]        sel_y_d;
    logic [7:0]        prod;
    int                idx;

    main u_mul (.x(op_x_q), .y(op_y_q), .o(prod));

    // Search starts at rr_ptr and wraps, so the last winner is looked at last.
    always_comb begin
        gnt_d     = '0;
        gnt_idx_d = '0;
        gnt_any_d = 1'b0;
        sel_x_d   = '0;
        sel_y_d   = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any_d && req_valid[idx]) begin
                gnt_any_d  = 1'b1;
                gnt_d[idx] = 1'b1;
                gnt_idx_d  = ID_W'(idx);
                sel_x_d    = req_x[4*idx +: 4];
                sel_y_d    = req_y[4*idx +: 4];
            end
        end
    end

    assign req_ready = (state_q == S_IDLE) ? gnt_d : '0;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;
    assign op_count  = op_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            op_x_q      <= '0;
            op_y_q      <= '0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_any_d) begin
                        op_x_q   <= sel_x_d;
                        op_y_q   <= sel_y_d;
                        gnt_id_q <= gnt_idx_d;
                        busy_q   <= 1'b1;
                        state_q  <= S_CALC;
                    end
                end
                S_CALC: begin
                    res_data_q  <= prod;
                    res_id_q    <= gnt_id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        op_count_q  <= op_count_q + CNT_W'(1);
                        rr_ptr_q    <= (gnt_id_q == ID_W'(NREQ-1)) ? '0
                                                                    : gnt_id_q + ID_W'(1);
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Scoreboard bench for mult_rr_scheduler: a cycle model predicts grants and status,
// expected products are queued at accept and compared while the result is offered.

module tb_mult_rr_scheduler;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [4*NREQ-1:0]   req_x;
    logic [4*NREQ-1:0]   req_y;
    logic [NREQ-1:0]     req_ready;
    logic                res_valid;
    logic                res_ready;
    logic [7:0]          res_data;
    logic [ID_W-1:0]     res_id;
    logic                busy;
    logic [CNT_W-1:0]    op_count;

    mult_rr_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   grant_log[$];
    int   total = 0;
    int   bad   = 0;
    int   m_state = 0;
    int   m_ptr   = 0;
    int   m_cnt   = 0;
    int   m_id;
    logic [3:0] m_eg;
    logic [7:0] m_a, m_b;
    exp_t m_front;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] rr_pick(input int ptr, input logic [3:0] v);
        int i;
        for (int k = 0; k < NREQ; k++) begin
            i = (ptr + k) % NREQ;
            if (v[i]) return 4'(1) << i;
        end
        return 4'b0;
    endfunction

    // Cycle model: evaluated mid-cycle, predicts what the next rising edge does.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_state = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            sb_q.delete();
        end else begin
            m_eg = (m_state == 0) ? rr_pick(m_ptr, req_valid) : 4'b0;
            chk("req_ready", req_ready, m_eg);
            chk("busy", busy, m_state != 0);
            chk("res_valid", res_valid, m_state == 2);
            chk("op_count", op_count, m_cnt % (1 << CNT_W));
            case (m_state)
                0: if (m_eg != 0) begin
                    m_id = 0;
                    for (int i = 0; i < NREQ; i++) if (m_eg[i]) m_id = i;
                    m_a = {4'b0, req_x[4*m_id +: 4]};
                    m_b = {4'b0, req_y[4*m_id +: 4]};
                    sb_q.push_back('{id: 2'(m_id), data: m_a * m_b});
                    grant_log.push_back(m_id);
                    m_state = 1;
                end
                1: m_state = 2;
                default: begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 0, 1);
                    end else begin
                        m_front = sb_q[0];
                        chk("res_data", res_data, m_front.data);
                        chk("res_id", res_id, m_front.id);
                        if (res_ready) begin
                            void'(sb_q.pop_front());
                            m_cnt++;
                            m_ptr   = (int'(m_front.id) + 1) % NREQ;
                            m_state = 0;
                        end
                    end
                end
            endcase
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int id, input int budget);
        bit got = 0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        if (!got) chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_drain(input int budget);
        bit done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && m_state == 0) done = 1;
        end
        if (!done) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        bit seen;
        rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0; res_ready = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single op on req0, latency and counter
        req_x[3:0] = 4'd15; req_y[3:0] = 4'd15; req_valid = 4'b0001;
        @(negedge clk) chk("t1_ready", req_ready, 4'b0001);
        @(posedge clk) #1 req_valid = '0;
        chk("t1_rv_edge1", res_valid, 0);
        @(posedge clk) #1;
        chk("t1_rv_edge2", res_valid, 1);
        chk("t1_data", res_data, 225);
        chk("t1_id", res_id, 0);
        res_ready = 1'b1;
        @(posedge clk) #1 res_ready = 1'b0;
        chk("t1_count", op_count, 1);

        // all four contend, rotation order and throughput
        do_reset();
        req_x = {4'd4, 4'd3, 4'd2, 4'd1};
        req_y = {4'd3, 4'd3, 4'd3, 4'd3};
        grant_log.delete();
        res_ready = 1'b1;
        req_valid = 4'hf;
        repeat (15) @(posedge clk);
        #1 req_valid = '0;
        chk("t2_ops_in_15", grant_log.size(), 5);
        if (grant_log.size() >= 5) begin
            chk("t2_order0", grant_log[0], 0);
            chk("t2_order1", grant_log[1], 1);
            chk("t2_order2", grant_log[2], 2);
            chk("t2_order3", grant_log[3], 3);
            chk("t2_order4", grant_log[4], 0);
        end
        wait_drain(10);
        chk("t2_count", op_count, 5);

        // consumer backpressure holds DONE
        res_ready = 1'b0;
        req_valid = 4'hf;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        chk("t3_res_valid_seen", seen, 1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("t3_hold_data", res_data, 6);
            chk("t3_hold_id", res_id, 1);
            chk("t3_hold_ready", req_ready, 0);
            chk("t3_hold_busy", busy, 1);
        end
        @(posedge clk) #1;
        req_valid = '0;
        res_ready = 1'b1;
        @(posedge clk) #1;
        chk("t3_count", op_count, 6);
        chk("t3_res_valid_off", res_valid, 0);

        // exhaustive operands through req2, operands changed right after accept
        c0 = m_cnt;
        req_valid = 4'b0100;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                req_x[11:8] = 4'(x);
                req_y[11:8] = 4'(y);
                wait_grant(2, 10);
                @(posedge clk) #1;
                req_x[11:8] = ~4'(x);
                req_y[11:8] = ~4'(y);
            end
        end
        req_valid = '0;
        wait_drain(10);
        chk("t4_ops", m_cnt - c0, 256);

        // pointer sits at 3 now; only req0 asks
        req_x[3:0] = 4'd5; req_y[3:0] = 4'd6; req_valid = 4'b0001;
        @(negedge clk) chk("t6_ptr_wrap", req_ready, 4'b0001);
        @(posedge clk) #1 req_valid = '0;
        wait_drain(10);

        // reset during CALC
        req_x[3:0] = 4'd7; req_y[3:0] = 4'd9; req_valid = 4'b0001;
        wait_grant(0, 10);
        @(posedge clk) #2;
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        chk("t5_res_valid", res_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_req_ready", req_ready, 0);
        chk("t5_res_data", res_data, 0);
        chk("t5_res_id", res_id, 0);
        chk("t5_op_count", op_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk) chk("t5_no_result", res_valid, 0);
        end

        // counter wrap with a narrow counter
        @(posedge clk) #1;
        res_ready = 1'b1;
        req_x[3:0] = 4'd2; req_y[3:0] = 4'd8;
        req_valid = 4'b0001;
        for (int n = 0; n < 15; n++) begin
            wait_grant(0, 10);
            @(posedge clk) #1;
        end
        req_valid = '0;
        wait_drain(10);
        chk("t6_count_max", op_count, 15);
        req_valid = 4'b0001;
        wait_grant(0, 10);
        @(posedge clk) #1 req_valid = '0;
        wait_drain(10);
        chk("t6_count_wrap", op_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
